// File: rtl/input_debouncer.sv
// input_debouncer: per-channel synchronizer + debouncer with registered
// one-cycle rise/fall pulses.
// Optional feature macro: INPUT_DEBOUNCER_SYNC_EN. When defined, a two-flop
// synchronizer precedes each channel's counter and adds two cycles of latency.
// When it is undefined, raw_in is sampled directly, for inputs that are already
// synchronous to clk.
module input_debouncer #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Counter only needs to reach STABLE_CYCLES-1, so it can never wrap.
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  // Per-channel sampled level that feeds the debounce counter.
  logic [WIDTH-1:0] samp;

`ifdef INPUT_DEBOUNCER_SYNC_EN
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  // Two-flop synchronizer per channel for asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign samp = sync2_reg;
`else
  assign samp = raw_in;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CW-1:0] cnt_reg;
      logic          db_reg;
      logic          rise_reg;
      logic          fall_reg;

      // Count consecutive samples that differ from the accepted level. Any
      // matching sample discards the run. Reaching the threshold accepts the
      // new level and emits a single pulse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          db_reg   <= 1'b0;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (samp[gi] == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            cnt_reg  <= '0;
            db_reg   <= samp[gi];
            rise_reg <= samp[gi];
            fall_reg <= ~samp[gi];
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      assign db_out[gi] = db_reg;
      assign rise[gi]   = rise_reg;
      assign fall[gi]   = fall_reg;
    end
  endgenerate

endmodule
